// File: rtl/digipot_spi_sequencer.sv
// rtl/digipot_spi_sequencer.sv - multi-channel digipot shadow registers with round-robin mode-0 SPI streaming
// Optional feature: DIGIPOT_MIDSCALE_RESET_EN (reset loads midscale into every channel and marks all dirty).
module digipot_spi_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1000,
    parameter int CS_GAP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    output logic              sck,
    output logic              sdo,
    output logic              cs_n,
    output logic              busy,
    output logic [NUM_CH-1:0] pending,
    output logic              frame_done
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    // One counter times both SCK half-periods and the CS gap, so it is sized for the longer.
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

`ifdef DIGIPOT_MIDSCALE_RESET_EN
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SCK_HI = 3'd2,
        SCK_LO = 3'd3,
        GAP    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  shreg;
    logic [ADDR_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]   pick;
    logic                pick_valid;
    logic [DATA_W-1:0]   shadow [NUM_CH];
    logic                wr_ok;
    logic                latch;
    logic                phase_end;
    logic                shift;
    logic                bit_inc;
    int                  idx;
    logic [ADDR_W-1:0]   cand;

    // Out-of-range channel addresses are dropped silently.
    assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH);

    // Data line is forced low whenever the chip is not selected.
    assign sdo = cs_n ? 1'b0 : shreg[FRAME_W-1];

    // Round-robin arbiter: first dirty channel at or after rr_ptr, wrapping at NUM_CH.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = ADDR_W'(idx);
            if (!pick_valid && pending[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state, SPI line decode and datapath strobes.
    always_comb begin
        state_nxt  = state;
        latch      = 1'b0;
        phase_end  = 1'b0;
        shift      = 1'b0;
        bit_inc    = 1'b0;
        cs_n       = 1'b1;
        sck        = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    latch     = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cs_n = 1'b0;
                if (cnt == DIV_LAST) begin
                    phase_end = 1'b1;
                    state_nxt = SCK_HI;
                end
            end
            SCK_HI: begin
                cs_n = 1'b0;
                sck  = 1'b1;
                if (cnt == DIV_LAST) begin
                    phase_end = 1'b1;
                    state_nxt = SCK_LO;
                    // Next bit appears right after the falling edge; the last bit is held instead.
                    shift     = (bit_cnt != BIT_LAST);
                end
            end
            SCK_LO: begin
                cs_n = 1'b0;
                if (cnt == DIV_LAST) begin
                    phase_end = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = GAP;
                    end else begin
                        bit_inc   = 1'b1;
                        state_nxt = SCK_HI;
                    end
                end
            end
            GAP: begin
                frame_done = (cnt == '0);
                if (cnt == GAP_LAST) begin
                    phase_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Phase timer: restarts at every phase boundary and rests at zero in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Bit counter and shift register; frame is {channel, shadow value}, MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (latch) begin
            bit_cnt <= '0;
            shreg   <= {pick, shadow[pick]};
        end else begin
            if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (shift) begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end
        end
    end

    // Round-robin pointer advances past the channel just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (latch) begin
            if (int'(pick) == NUM_CH - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= pick + ADDR_W'(1);
            end
        end
    end

    // Shadow registers and dirty bits; a write in the latch cycle re-dirties the channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef DIGIPOT_MIDSCALE_RESET_EN
            pending <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= MIDSCALE;
            end
`else
            pending <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
`endif
        end else begin
            if (latch) begin
                pending[pick] <= 1'b0;
            end
            if (wr_ok) begin
                pending[wr_ch] <= 1'b1;
                shadow[wr_ch]  <= wr_data;
            end
        end
    end

    // Busy spans back-to-back frames, dropping only when the gap ends with nothing dirty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (latch) begin
            busy <= 1'b1;
        end else if (state == GAP && phase_end) begin
            busy <= |pending;
        end
    end

endmodule

// File: tb/tb_digipot_spi_sequencer.sv
// tb/tb_digipot_spi_sequencer.sv - directed self-checking bench for digipot_spi_sequencer
module tb_digipot_spi_sequencer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic       sck, sdo, cs_n, busy, frame_done;
    logic [3:0] pending;

    logic       wr_en3;
    logic [1:0] wr_ch3;
    logic [7:0] wr_data3;
    logic       sck3, sdo3, cs_n3, busy3, frame_done3;
    logic [2:0] pending3;

    int compared;
    int mismatched;

    logic [9:0] frames [$];
    int         lens [$];
    int         nbits_q [$];
    int         gaps [$];
    logic [9:0] cur;
    int         nbits, low_len, high_len, fd_cnt, busy_low, cs3_low;
    bit         arm, seen;
    logic       cs_q, sck_q;

    digipot_spi_sequencer #(.NUM_CH(4), .ADDR_W(2), .DATA_W(8), .CLK_DIV(2), .CS_GAP(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .sck(sck), .sdo(sdo), .cs_n(cs_n), .busy(busy), .pending(pending), .frame_done(frame_done)
    );

    digipot_spi_sequencer #(.NUM_CH(3), .ADDR_W(2), .DATA_W(8), .CLK_DIV(2), .CS_GAP(2)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data3),
        .sck(sck3), .sdo(sdo3), .cs_n(cs_n3), .busy(busy3), .pending(pending3), .frame_done(frame_done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPI slave model: samples sdo on sck rising edges, records frames, cs_n timing and pulses.
    initial begin
        cs_q = 1'b1; sck_q = 1'b0; cur = '0; nbits = 0; low_len = 0; high_len = 0;
        fd_cnt = 0; busy_low = 0; cs3_low = 0; arm = 0; seen = 0;
    end
    always @(negedge clk) begin
        if (!cs_n) begin
            if (cs_q) begin
                if (seen) gaps.push_back(high_len);
                low_len = 0; cur = '0; nbits = 0;
            end
            low_len++;
            if (sck && !sck_q) begin
                cur = {cur[8:0], sdo};
                nbits++;
            end
        end else begin
            if (!cs_q) begin
                frames.push_back(cur); lens.push_back(low_len); nbits_q.push_back(nbits);
                seen = 1; high_len = 0;
            end
            high_len++;
        end
        if (frame_done) fd_cnt++;
        if (arm && !busy) busy_low++;
        if (!cs_n3) cs3_low++;
        cs_q = cs_n; sck_q = sck;
    end

    task automatic clear_mon();
        frames.delete(); lens.delete(); nbits_q.delete(); gaps.delete();
        fd_cnt = 0; seen = 0; nbits = 0;
    endtask

    // Caller sits on a negedge; returns on the following negedge with wr_en low.
    task automatic wr(input logic [1:0] ch, input logic [7:0] data);
        wr_en = 1'b1; wr_ch = ch; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n;
        n = 0;
        while (!(busy === 1'b0 && pending === 4'b0000 && cs_n === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= budget) begin
            mismatched++;
            $display("FAIL %s timeout: busy=%b pending=%b after %0d cycles, required idle", name, busy, pending, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 0; wr_ch = 0; wr_data = 0; wr_en3 = 0; wr_ch3 = 0; wr_data3 = 0;
        repeat (3) @(negedge clk);
        compared++;
        if ({cs_n, sck, sdo, busy, frame_done} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_outputs: cs_n/sck/sdo/busy/fd=%b required 10000", {cs_n, sck, sdo, busy, frame_done});
        end
        compared++;
`ifdef DIGIPOT_MIDSCALE_RESET_EN
        if (pending !== 4'b1111) begin
            mismatched++;
            $display("FAIL reset_pending: %b required 1111", pending);
        end
`else
        if (pending !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_pending: %b required 0000", pending);
        end
`endif
        rst = 1'b0;
`ifndef DIGIPOT_MIDSCALE_RESET_EN
        repeat (50) @(negedge clk);
        compared++;
        if (frames.size() !== 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_frame: frames=%0d busy=%b required 0 and 0", frames.size(), busy);
        end
`endif
    endtask

`ifdef DIGIPOT_MIDSCALE_RESET_EN
    task automatic test_midscale();
        logic [9:0] exp [4];
        exp[0] = 10'h080; exp[1] = 10'h180; exp[2] = 10'h280; exp[3] = 10'h380;
        wait_quiet(600, "midscale");
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (i >= frames.size() || frames[i] !== exp[i]) begin
                mismatched++;
                $display("FAIL midscale_frame%0d: got %h required %h", i, (i < frames.size()) ? frames[i] : 10'h3ff, exp[i]);
            end
        end
        compared++;
        if (frames.size() !== 4) begin
            mismatched++;
            $display("FAIL midscale_count: %0d required 4", frames.size());
        end
        clear_mon();
    endtask
`endif

    task automatic test_single();
        clear_mon();
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 2'd2; wr_data = 8'hA5;
        @(posedge clk); #1;
        wr_en = 1'b0;
        compared++;
        if (pending !== 4'b0100 || cs_n !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_edge_n: pending=%b cs_n=%b busy=%b required 0100 1 0", pending, cs_n, busy);
        end
        @(posedge clk); #1;
        compared++;
        if (pending !== 4'b0000 || cs_n !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL latency_edge_n1: pending=%b cs_n=%b busy=%b required 0000 0 1", pending, cs_n, busy);
        end
        wait_quiet(200, "single");
        compared++;
        if (frames.size() !== 1 || frames[0] !== 10'h2A5 || nbits_q[0] !== 10) begin
            mismatched++;
            $display("FAIL single_frame: count=%0d data=%h bits=%0d required 1 2a5 10",
                     frames.size(), (frames.size() > 0) ? frames[0] : 10'h3ff, (nbits_q.size() > 0) ? nbits_q[0] : -1);
        end
        compared++;
        if (lens.size() < 1 || lens[0] !== 42) begin
            mismatched++;
            $display("FAIL single_cs_low: %0d required 42", (lens.size() > 0) ? lens[0] : -1);
        end
        compared++;
        if (fd_cnt !== 1 || pending !== 4'b0000) begin
            mismatched++;
            $display("FAIL single_done: frame_done pulses=%0d pending=%b required 1 0000", fd_cnt, pending);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp [3];
        int n;
        exp[0] = 10'h011; exp[1] = 10'h122; exp[2] = 10'h333;
        clear_mon();
        @(negedge clk);
        wr(2'd0, 8'h11);
        wr(2'd3, 8'h33);
        wr(2'd1, 8'h22);
        busy_low = 0; arm = 1;
        n = 0;
        while (frames.size() < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        arm = 0;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (i >= frames.size() || frames[i] !== exp[i]) begin
                mismatched++;
                $display("FAIL rr_frame%0d: got %h required %h", i, (i < frames.size()) ? frames[i] : 10'h3ff, exp[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (i >= gaps.size() || gaps[i] !== 3) begin
                mismatched++;
                $display("FAIL rr_gap%0d: got %0d required 3", i, (i < gaps.size()) ? gaps[i] : -1);
            end
        end
        compared++;
        if (busy_low !== 0) begin
            mismatched++;
            $display("FAIL rr_busy: low for %0d cycles required 0", busy_low);
        end
        wait_quiet(200, "rr");
    endtask

    task automatic test_coalesce();
        int n;
        clear_mon();
        @(negedge clk);
        wr(2'd0, 8'h55);
        n = 0;
        while (cs_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        wr(2'd1, 8'h01);
        wr(2'd1, 8'h02);
        wait_quiet(400, "coalesce");
        compared++;
        if (frames.size() !== 2 || frames[0] !== 10'h055 || frames[1] !== 10'h102) begin
            mismatched++;
            $display("FAIL coalesce: count=%0d f0=%h f1=%h required 2 055 102", frames.size(),
                     (frames.size() > 0) ? frames[0] : 10'h3ff, (frames.size() > 1) ? frames[1] : 10'h3ff);
        end
    endtask

    task automatic test_write_wins();
        clear_mon();
        @(negedge clk);
        wr(2'd2, 8'h10);
        repeat (10) @(negedge clk);
        wr(2'd2, 8'h20);
        wait_quiet(400, "midframe");
        compared++;
        if (frames.size() !== 2 || frames[0] !== 10'h210 || frames[1] !== 10'h220) begin
            mismatched++;
            $display("FAIL midframe_rewrite: count=%0d f0=%h f1=%h required 2 210 220", frames.size(),
                     (frames.size() > 0) ? frames[0] : 10'h3ff, (frames.size() > 1) ? frames[1] : 10'h3ff);
        end
        clear_mon();
        @(negedge clk);
        wr(2'd1, 8'h44);
        wr(2'd1, 8'h66);
        wait_quiet(400, "latch_cycle");
        compared++;
        if (frames.size() !== 2 || frames[0] !== 10'h144 || frames[1] !== 10'h166) begin
            mismatched++;
            $display("FAIL latch_cycle_write: count=%0d f0=%h f1=%h required 2 144 166", frames.size(),
                     (frames.size() > 0) ? frames[0] : 10'h3ff, (frames.size() > 1) ? frames[1] : 10'h3ff);
        end
    endtask

    task automatic test_invalid_channel();
        @(negedge clk);
        cs3_low = 0;
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 8'h77;
        @(negedge clk);
        wr_en3 = 1'b0;
        compared++;
        if (pending3 !== 3'b000) begin
            mismatched++;
            $display("FAIL invalid_pending: %b required 000", pending3);
        end
        repeat (100) @(negedge clk);
        compared++;
        if (cs3_low !== 0 || busy3 !== 1'b0) begin
            mismatched++;
            $display("FAIL invalid_no_frame: cs_n low %0d cycles busy=%b required 0 0", cs3_low, busy3);
        end
        wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_data3 = 8'h99;
        @(negedge clk);
        wr_en3 = 1'b0;
        repeat (100) @(negedge clk);
        compared++;
        if (cs3_low !== 42 || pending3 !== 3'b000) begin
            mismatched++;
            $display("FAIL valid_ch2_nch3: cs_n low %0d cycles pending=%b required 42 000", cs3_low, pending3);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        clear_mon();
        @(negedge clk);
        wr(2'd3, 8'h5A);
        n = 0;
        while (!(cs_n === 1'b0 && nbits == 5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 200) begin
            mismatched++;
            $display("FAIL rst_mid_reach_bit5: bits seen %0d required 5", nbits);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({cs_n, sck, sdo, busy, frame_done} !== 5'b10000) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: cs_n/sck/sdo/busy/fd=%b required 10000", {cs_n, sck, sdo, busy, frame_done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (250) @(negedge clk);
`ifdef DIGIPOT_MIDSCALE_RESET_EN
        compared++;
        if (frames.size() !== 4 || frames[0] !== 10'h080 || frames[3] !== 10'h380) begin
            mismatched++;
            $display("FAIL rst_mid_after: frames=%0d required 4 midscale frames", frames.size());
        end
`else
        compared++;
        if (frames.size() !== 0 || pending !== 4'b0000 || cs_n !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_after: frames=%0d pending=%b cs_n=%b required 0 0000 1", frames.size(), pending, cs_n);
        end
`endif
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
`ifdef DIGIPOT_MIDSCALE_RESET_EN
        test_midscale();
`endif
        test_single();
        test_round_robin();
        test_coalesce();
        test_write_wins();
        test_invalid_channel();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
